uart_cmd_master: RTL and testbench

Host-side command initiator for the 3-byte UART command protocol that `dig_core` answers. It accepts one command (opcode + 16-bit argument) over a valid/ready port, serializes it as three bytes into a `uart_transceiver` transmit port, and for read opcodes waits for the single response byte. It then reports the result, or a timeout error, on a one-cycle response strobe. It sits between a sequencer or bench driver and the byte-level UART transceiver.

---
 rtl/uart_cmd_pkg.sv | 19 +
 rtl/cmd_timeout_ctr.sv | 42 ++++
 rtl/uart_cmd_master.sv | 150 +++++++++++++++
 tb/tb_uart_cmd_master.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the 3-byte UART command initiator.
package uart_cmd_pkg;

   localparam int unsigned FRAME_BYTES = 3;
   localparam logic [7:0]  OP_WRITE    = 8'h01;
   localparam logic [7:0]  OP_READ     = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_TX,
      ST_WAIT_RSP,
      ST_RESP
   } cmd_state_e;

   // Element 0 is the opcode (sent first), then arg[15:8], then arg[7:0].
   typedef logic [FRAME_BYTES-1:0][7:0] cmd_frame_t;

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Saturating wait-state cycle counter; expired_o is high while count == LIMIT-1.
module cmd_timeout_ctr #(
   parameter int unsigned LIMIT = 200000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned        CNT_W    = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0]   CNT_TERM = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_n;
   logic             r_expired;

   always_comb begin
      w_count_n = r_count;
      if (clr_i) begin
         w_count_n = '0;
      end else if (en_i && (r_count != CNT_MAX)) begin
         w_count_n = r_count + CNT_W'(1);
      end
   end

   // Expiry flag tracks the count register so it is valid in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_expired <= 1'b0;
      end else begin
         r_count   <= w_count_n;
         r_expired <= (w_count_n == CNT_TERM);
      end
   end

   assign expired_o = r_expired;

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side command initiator: sends op/arg_hi/arg_lo to a UART transmitter,
// optionally waits for one response byte, and reports result or timeout.
module uart_cmd_master
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 200000,
   parameter logic [7:0]  READ_OP        = OP_READ
) (
   input  logic        clk,
   input  logic        rst_raw_n,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [7:0]  cmd_op_i,
   input  logic [15:0] cmd_arg_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_wr_o,
   input  logic        tx_done_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_done_i,
   output logic        rsp_valid_o,
   output logic [7:0]  rsp_data_o,
   output logic        rsp_err_o,
   output logic        stray_o
);

   localparam int unsigned     IDX_W    = $clog2(FRAME_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   cmd_state_e       r_state, w_state_n;
   cmd_frame_t       r_frame, w_frame_n;
   logic [IDX_W-1:0] r_idx, w_idx_n;
   logic [7:0]       r_tx_data, w_tx_data_n;
   logic [7:0]       r_rsp_data, w_rsp_data_n;
   logic             r_rsp_err, w_rsp_err_n;
   logic             r_tx_wr, r_ready, r_rsp_valid, r_stray;
   logic             w_ctr_clr, w_ctr_en, w_expired;

   cmd_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_raw_n),
      .clr_i     (w_ctr_clr),
      .en_i      (w_ctr_en),
      .expired_o (w_expired)
   );

   // Next-state and datapath updates; events take priority over timeout.
   always_comb begin
      w_state_n    = r_state;
      w_frame_n    = r_frame;
      w_idx_n      = r_idx;
      w_rsp_data_n = r_rsp_data;
      w_rsp_err_n  = r_rsp_err;
      w_ctr_clr    = 1'b0;
      w_ctr_en     = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               w_frame_n[0] = cmd_op_i;
               w_frame_n[1] = cmd_arg_i[15:8];
               w_frame_n[2] = cmd_arg_i[7:0];
               w_idx_n      = '0;
               w_state_n    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_ctr_clr = 1'b1;
            w_state_n = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            w_ctr_en = 1'b1;
            if (tx_done_i) begin
               if (r_idx != LAST_IDX) begin
                  w_idx_n   = r_idx + IDX_W'(1);
                  w_state_n = ST_LOAD;
               end else if (r_frame[0] == READ_OP) begin
                  w_ctr_clr = 1'b1;
                  w_state_n = ST_WAIT_RSP;
               end else begin
                  w_rsp_data_n = 8'h00;
                  w_rsp_err_n  = 1'b0;
                  w_state_n    = ST_RESP;
               end
            end else if (w_expired) begin
               w_rsp_data_n = 8'hFF;
               w_rsp_err_n  = 1'b1;
               w_state_n    = ST_RESP;
            end
         end
         ST_WAIT_RSP: begin
            w_ctr_en = 1'b1;
            if (rx_done_i) begin
               w_rsp_data_n = rx_data_i;
               w_rsp_err_n  = 1'b0;
               w_state_n    = ST_RESP;
            end else if (w_expired) begin
               w_rsp_data_n = 8'hFF;
               w_rsp_err_n  = 1'b1;
               w_state_n    = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_n = ST_IDLE;
         end
         default: begin
            w_state_n = ST_IDLE;
         end
      endcase

      w_tx_data_n = (w_state_n == ST_LOAD) ? w_frame_n[w_idx_n] : r_tx_data;
   end

   // Outputs are registered from the next state so strobes align with their state.
   always_ff @(posedge clk or negedge rst_raw_n) begin
      if (!rst_raw_n) begin
         r_state     <= ST_IDLE;
         r_frame     <= '0;
         r_idx       <= '0;
         r_tx_data   <= 8'h00;
         r_tx_wr     <= 1'b0;
         r_ready     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 8'h00;
         r_rsp_err   <= 1'b0;
         r_stray     <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_frame     <= w_frame_n;
         r_idx       <= w_idx_n;
         r_tx_data   <= w_tx_data_n;
         r_tx_wr     <= (w_state_n == ST_LOAD);
         r_ready     <= (w_state_n == ST_IDLE);
         r_rsp_valid <= (w_state_n == ST_RESP);
         r_rsp_data  <= w_rsp_data_n;
         r_rsp_err   <= w_rsp_err_n;
         r_stray     <= rx_done_i && (r_state != ST_WAIT_RSP);
      end
   end

   assign cmd_ready_o = r_ready;
   assign tx_data_o   = r_tx_data;
   assign tx_wr_o     = r_tx_wr;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;
   assign rsp_err_o   = r_rsp_err;
   assign stray_o     = r_stray;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Scoreboard bench for uart_cmd_master with a behavioral transmitter/remote model.
module tb_uart_cmd_master;
   import uart_cmd_pkg::*;

   localparam int unsigned TO     = 1000;
   localparam int          BUDGET = 3000;

   typedef struct packed {
      logic [7:0] data;
      logic       err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_raw_n = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [7:0]  cmd_op_i = 8'h00;
   logic [15:0] cmd_arg_i = 16'h0000;
   logic [7:0]  tx_data_o;
   logic        tx_wr_o;
   logic        tx_done_i = 1'b0;
   logic [7:0]  rx_data_i = 8'h00;
   logic        rx_done_i = 1'b0;
   logic        rsp_valid_o;
   logic [7:0]  rsp_data_o;
   logic        rsp_err_o;
   logic        stray_o;

   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   cyc = 0;
   int   wr_cnt = 0, done_cnt = 0, rsp_cnt = 0, stray_cnt = 0;
   int   done_cyc = 0, rsp_cyc = 0, acc_cyc = 0;
   int   tx_lat = 2, tx_cnt = 0, frame_pos = 0;
   bit   tx_auto = 1'b1;
   logic [7:0] cur_byte = 8'h00;
   logic [7:0] exp_tx[$];
   rsp_t       exp_rsp[$];

   uart_cmd_master #(
      .TIMEOUT_CYCLES (TO),
      .READ_OP        (OP_READ)
   ) dut (
      .clk         (clk),
      .rst_raw_n   (rst_raw_n),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_op_i    (cmd_op_i),
      .cmd_arg_i   (cmd_arg_i),
      .tx_data_o   (tx_data_o),
      .tx_wr_o     (tx_wr_o),
      .tx_done_i   (tx_done_i),
      .rx_data_i   (rx_data_i),
      .rx_done_i   (rx_done_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .stray_o     (stray_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model and byte scoreboard, evaluated mid-cycle.
   always @(negedge clk) begin
      logic [7:0] eb;
      if (tx_done_i) tx_done_i = 1'b0;
      if (!rst_raw_n) begin
         tx_cnt    = 0;
         frame_pos = 0;
      end else begin
         if (tx_wr_o) begin
            eb = (exp_tx.size() != 0) ? exp_tx.pop_front() : 8'hxx;
            total_cnt++;
            if (tx_data_o !== eb)
               $display("FAIL tx_byte: got %02h expected %02h (cycle %0d)", tx_data_o, eb, cyc);
            else pass_cnt++;
            if (frame_pos != 0) begin
               total_cnt++;
               if (cyc !== done_cyc + 1)
                  $display("FAIL tx_gap: write in cycle %0d expected %0d", cyc, done_cyc + 1);
               else pass_cnt++;
            end
            frame_pos++;
            wr_cnt++;
            cur_byte = tx_data_o;
            tx_cnt   = tx_lat;
         end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0 && tx_auto) begin
               total_cnt++;
               if (tx_data_o !== cur_byte)
                  $display("FAIL tx_hold: got %02h expected %02h", tx_data_o, cur_byte);
               else pass_cnt++;
               tx_done_i = 1'b1;
               done_cyc  = cyc;
               done_cnt++;
            end
         end
         if (rsp_valid_o) begin
            rsp_cnt++;
            rsp_cyc   = cyc;
            frame_pos = 0;
         end
         if (stray_o) stray_cnt++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [15:0] arg);
      int n = 0;
      while (cmd_ready_o !== 1'b1 && n < BUDGET) begin step(); n++; end
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_arg_i   = arg;
      exp_tx.push_back(op);
      exp_tx.push_back(arg[15:8]);
      exp_tx.push_back(arg[7:0]);
      acc_cyc = cyc;
      step();
      cmd_valid_i = 1'b0;
      total_cnt++;
      if ({tx_wr_o, cmd_ready_o} !== 2'b10)
         $display("FAIL accept_latency: wr/ready got %b expected 10", {tx_wr_o, cmd_ready_o});
      else pass_cnt++;
   endtask

   task automatic wait_rsp(input string name, output logic ok, output int ready_hi);
      int n = 0;
      ready_hi = 0;
      while (rsp_valid_o !== 1'b1 && n < BUDGET) begin
         if (cmd_ready_o === 1'b1) ready_hi++;
         step();
         n++;
      end
      ok = (rsp_valid_o === 1'b1);
      if (!ok) begin
         total_cnt++;
         $display("FAIL %s_no_rsp: got no rsp_valid_o expected one within %0d cycles", name, BUDGET);
      end
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < BUDGET) begin step(); n++; end
   endtask

   task automatic test_reset();
      rst_raw_n = 1'b0;
      repeat (3) step();
      total_cnt++;
      if ({cmd_ready_o, tx_wr_o, rsp_valid_o, rsp_err_o, stray_o, tx_data_o, rsp_data_o} !== {5'b10000, 16'h0000})
         $display("FAIL reset_hold: got %b expected %b",
                  {cmd_ready_o, tx_wr_o, rsp_valid_o, rsp_err_o, stray_o, tx_data_o, rsp_data_o}, {5'b10000, 16'h0000});
      else pass_cnt++;
      rst_raw_n = 1'b1;
      repeat (2) step();
      total_cnt++;
      if ({cmd_ready_o, tx_wr_o, rsp_valid_o, stray_o} !== 4'b1000)
         $display("FAIL reset_release: got %b expected 1000", {cmd_ready_o, tx_wr_o, rsp_valid_o, stray_o});
      else pass_cnt++;
   endtask

   task automatic test_write();
      int base = wr_cnt, rhi;
      logic ok;
      rsp_t e;
      send_cmd(OP_WRITE, 16'h00A1);
      exp_rsp.push_back('{data: 8'h00, err: 1'b0});
      wait_rsp("write", ok, rhi);
      if (ok) begin
         e = exp_rsp.pop_front();
         total_cnt++;
         if ({rsp_data_o, rsp_err_o} !== {e.data, e.err})
            $display("FAIL write_rsp: got %02h/%b expected %02h/%b", rsp_data_o, rsp_err_o, e.data, e.err);
         else pass_cnt++;
         total_cnt++;
         if (rsp_cyc !== done_cyc + 1)
            $display("FAIL write_rsp_latency: got cycle %0d expected %0d", rsp_cyc, done_cyc + 1);
         else pass_cnt++;
         total_cnt++;
         if ((wr_cnt - base) !== 3 || rhi !== 0)
            $display("FAIL write_frame: writes %0d ready_hi %0d expected 3 and 0", wr_cnt - base, rhi);
         else pass_cnt++;
         step();
         total_cnt++;
         if ({cmd_ready_o, rsp_valid_o} !== 2'b10)
            $display("FAIL write_ready_return: got %b expected 10", {cmd_ready_o, rsp_valid_o});
         else pass_cnt++;
      end
   endtask

   task automatic test_read();
      int base = done_cnt, sc, rhi;
      logic ok;
      rsp_t e;
      send_cmd(OP_READ, 16'h0000);
      exp_rsp.push_back('{data: 8'h5C, err: 1'b0});
      wait_done(base + 3);
      repeat (4) step();
      sc = stray_cnt;
      rx_data_i = 8'h5C;
      rx_done_i = 1'b1;
      step();
      rx_done_i = 1'b0;
      rx_data_i = 8'h00;
      total_cnt++;
      if (rsp_valid_o !== 1'b1)
         $display("FAIL read_rsp_latency: rsp_valid_o got %b expected 1 one cycle after rx_done", rsp_valid_o);
      else pass_cnt++;
      wait_rsp("read", ok, rhi);
      if (ok) begin
         e = exp_rsp.pop_front();
         total_cnt++;
         if ({rsp_data_o, rsp_err_o} !== {e.data, e.err})
            $display("FAIL read_rsp: got %02h/%b expected %02h/%b", rsp_data_o, rsp_err_o, e.data, e.err);
         else pass_cnt++;
      end
      step();
      total_cnt++;
      if (stray_cnt !== sc)
         $display("FAIL read_no_stray: got %0d stray pulses expected 0", stray_cnt - sc);
      else pass_cnt++;
   endtask

   task automatic test_stray();
      int base = wr_cnt, sc, rhi;
      logic ok;
      rsp_t e;
      tx_lat = 20;
      send_cmd(OP_WRITE, 16'h1234);
      exp_rsp.push_back('{data: 8'h00, err: 1'b0});
      repeat (3) step();
      sc = stray_cnt;
      rx_data_i = 8'h77;
      rx_done_i = 1'b1;
      step();
      rx_done_i = 1'b0;
      total_cnt++;
      if (stray_o !== 1'b1)
         $display("FAIL stray_pulse: got %b expected 1", stray_o);
      else pass_cnt++;
      step();
      total_cnt++;
      if (stray_o !== 1'b0 || (stray_cnt - sc) !== 1)
         $display("FAIL stray_width: stray_o %b pulses %0d expected 0 and 1", stray_o, stray_cnt - sc);
      else pass_cnt++;
      wait_rsp("stray", ok, rhi);
      if (ok) begin
         e = exp_rsp.pop_front();
         total_cnt++;
         if ({rsp_data_o, rsp_err_o, 32'(wr_cnt - base)} !== {e.data, e.err, 32'd3})
            $display("FAIL stray_frame: got %02h/%b writes %0d expected %02h/%b writes 3",
                     rsp_data_o, rsp_err_o, wr_cnt - base, e.data, e.err);
         else pass_cnt++;
      end
      tx_lat = 2;
   endtask

   task automatic test_back_to_back();
      int base, rhi, ra, n = 0;
      logic ok;
      rsp_t e;
      while (cmd_ready_o !== 1'b1 && n < BUDGET) begin step(); n++; end
      base = wr_cnt;
      cmd_valid_i = 1'b1;
      cmd_op_i    = OP_WRITE;
      cmd_arg_i   = 16'h1234;
      exp_tx.push_back(8'h01); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
      exp_rsp.push_back('{data: 8'h00, err: 1'b0});
      step();
      cmd_arg_i = 16'h5678;
      exp_tx.push_back(8'h01); exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
      exp_rsp.push_back('{data: 8'h00, err: 1'b0});
      wait_rsp("b2b_first", ok, rhi);
      ra = cyc;
      if (ok) begin
         e = exp_rsp.pop_front();
         total_cnt++;
         if ({rsp_data_o, rsp_err_o} !== {e.data, e.err} || rhi !== 0 || (wr_cnt - base) !== 3)
            $display("FAIL b2b_first: rsp %02h/%b ready_hi %0d writes %0d expected %02h/%b 0 3",
                     rsp_data_o, rsp_err_o, rhi, wr_cnt - base, e.data, e.err);
         else pass_cnt++;
      end
      step();
      total_cnt++;
      if (cmd_ready_o !== 1'b1)
         $display("FAIL b2b_ready: got %b expected 1 in cycle %0d", cmd_ready_o, ra + 1);
      else pass_cnt++;
      step();
      cmd_valid_i = 1'b0;
      total_cnt++;
      if (tx_wr_o !== 1'b1 || cmd_ready_o !== 1'b0)
         $display("FAIL b2b_second_accept: wr/ready got %b expected 10", {tx_wr_o, cmd_ready_o});
      else pass_cnt++;
      wait_rsp("b2b_second", ok, rhi);
      if (ok) begin
         e = exp_rsp.pop_front();
         total_cnt++;
         if ({rsp_data_o, rsp_err_o} !== {e.data, e.err} || (wr_cnt - base) !== 6)
            $display("FAIL b2b_second: rsp %02h/%b writes %0d expected %02h/%b 6",
                     rsp_data_o, rsp_err_o, wr_cnt - base, e.data, e.err);
         else pass_cnt++;
      end
   endtask

   task automatic test_read_timeout();
      int base = done_cnt, t, rhi;
      logic ok;
      rsp_t e;
      send_cmd(OP_READ, 16'h00F0);
      exp_rsp.push_back('{data: 8'hFF, err: 1'b1});
      wait_done(base + 3);
      t = done_cyc;
      wait_rsp("read_timeout", ok, rhi);
      if (ok) begin
         e = exp_rsp.pop_front();
         total_cnt++;
         if ({rsp_data_o, rsp_err_o} !== {e.data, e.err})
            $display("FAIL read_timeout_rsp: got %02h/%b expected %02h/%b", rsp_data_o, rsp_err_o, e.data, e.err);
         else pass_cnt++;
         total_cnt++;
         if (rsp_cyc !== t + 1 + int'(TO))
            $display("FAIL read_timeout_latency: got cycle %0d expected %0d", rsp_cyc, t + 1 + int'(TO));
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_midframe();
      int base = wr_cnt, rc, rhi, n = 0;
      logic ok;
      rsp_t e;
      tx_lat = 4;
      send_cmd(OP_WRITE, 16'h00A1);
      while (wr_cnt < base + 2 && n < BUDGET) begin step(); n++; end
      rst_raw_n = 1'b0;
      #1;
      rc = rsp_cnt;
      total_cnt++;
      if ({cmd_ready_o, tx_wr_o, rsp_valid_o, rsp_err_o, stray_o, tx_data_o, rsp_data_o} !== {5'b10000, 16'h0000})
         $display("FAIL reset_async: got %b expected %b",
                  {cmd_ready_o, tx_wr_o, rsp_valid_o, rsp_err_o, stray_o, tx_data_o, rsp_data_o}, {5'b10000, 16'h0000});
      else pass_cnt++;
      repeat (3) step();
      exp_tx.delete();
      rst_raw_n = 1'b1;
      repeat (3) step();
      total_cnt++;
      if (rsp_cnt !== rc || cmd_ready_o !== 1'b1)
         $display("FAIL reset_no_rsp: rsp pulses %0d ready %b expected 0 and 1", rsp_cnt - rc, cmd_ready_o);
      else pass_cnt++;
      tx_lat = 2;
      base = wr_cnt;
      send_cmd(OP_WRITE, 16'h00C3);
      exp_rsp.push_back('{data: 8'h00, err: 1'b0});
      wait_rsp("reset_fresh", ok, rhi);
      if (ok) begin
         e = exp_rsp.pop_front();
         total_cnt++;
         if ({rsp_data_o, rsp_err_o} !== {e.data, e.err} || (wr_cnt - base) !== 3)
            $display("FAIL reset_fresh: rsp %02h/%b writes %0d expected %02h/%b 3",
                     rsp_data_o, rsp_err_o, wr_cnt - base, e.data, e.err);
         else pass_cnt++;
      end
   endtask

   task automatic test_same_cycle();
      int base = done_cnt, t, n = 0;
      rsp_t e;
      send_cmd(OP_READ, 16'h0102);
      exp_rsp.push_back('{data: 8'hA5, err: 1'b0});
      wait_done(base + 3);
      t = done_cyc;
      while (cyc < t + int'(TO) && n < BUDGET) begin step(); n++; end
      rx_data_i = 8'hA5;
      rx_done_i = 1'b1;
      step();
      rx_done_i = 1'b0;
      rx_data_i = 8'h00;
      e = exp_rsp.pop_front();
      total_cnt++;
      if ({rsp_valid_o, rsp_data_o, rsp_err_o} !== {1'b1, e.data, e.err})
         $display("FAIL same_cycle: got v=%b %02h/%b expected v=1 %02h/%b",
                  rsp_valid_o, rsp_data_o, rsp_err_o, e.data, e.err);
      else pass_cnt++;
      step();
   endtask

   task automatic test_tx_timeout();
      int base = wr_cnt, w, rhi;
      logic ok;
      rsp_t e;
      tx_auto = 1'b0;
      send_cmd(OP_WRITE, 16'hBEEF);
      w = acc_cyc + 1;
      exp_rsp.push_back('{data: 8'hFF, err: 1'b1});
      wait_rsp("tx_timeout", ok, rhi);
      if (ok) begin
         e = exp_rsp.pop_front();
         total_cnt++;
         if ({rsp_data_o, rsp_err_o} !== {e.data, e.err} || (wr_cnt - base) !== 1)
            $display("FAIL tx_timeout_rsp: rsp %02h/%b writes %0d expected %02h/%b 1",
                     rsp_data_o, rsp_err_o, wr_cnt - base, e.data, e.err);
         else pass_cnt++;
         total_cnt++;
         if (rsp_cyc !== w + 1 + int'(TO))
            $display("FAIL tx_timeout_latency: got cycle %0d expected %0d", rsp_cyc, w + 1 + int'(TO));
         else pass_cnt++;
      end
      exp_tx.delete();
      tx_auto = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_stray();
      test_back_to_back();
      test_read_timeout();
      test_reset_midframe();
      test_same_cycle();
      test_tx_timeout();
      repeat (3) step();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
